// File: rtl/drc_path_tracker_if.sv
// Bus bundle for drc_path_tracker: request in, PCIe read out, completion beats in, AXI descriptors out.
interface drc_path_tracker_if #(
    parameter int P_PATHS = 4,
    parameter int P_DW    = 4
);
    localparam int PW = (P_PATHS > 1) ? $clog2(P_PATHS) : 1;

    logic [31:0]   req_host_addr;
    logic [31:0]   req_dev_addr;
    logic [12:0]   req_len;
    logic          req_valid;
    logic          req_ready;

    logic [31:0]   dma_read_addr;
    logic [9:0]    dma_read_len;
    logic [7:0]    dma_read_tag;
    logic          dma_read_valid;
    logic          dma_read_done;

    logic [7:0]    cpl_tag;
    logic [P_DW-1:0] cpl_dwen;
    logic          cpl_valid;

    logic [31:0]   desc_addr;
    logic [7:0]    desc_len;
    logic [PW-1:0] desc_path;
    logic          desc_valid;
    logic          desc_ready;

    // Handshakes: req_ready is a one-cycle accept pulse while req_valid is high; dma_read_valid
    // holds a stable payload until the cycle after dma_read_done; cpl_valid is a strobe with no
    // back-pressure; a descriptor moves on the edge where desc_valid and desc_ready are both high.
    modport slave (
        input  req_host_addr, req_dev_addr, req_len, req_valid,
        output req_ready,
        output dma_read_addr, dma_read_len, dma_read_tag, dma_read_valid,
        input  dma_read_done,
        input  cpl_tag, cpl_dwen, cpl_valid,
        output desc_addr, desc_len, desc_path, desc_valid,
        input  desc_ready
    );

    modport master (
        output req_host_addr, req_dev_addr, req_len, req_valid,
        input  req_ready,
        input  dma_read_addr, dma_read_len, dma_read_tag, dma_read_valid,
        output dma_read_done,
        output cpl_tag, cpl_dwen, cpl_valid,
        input  desc_addr, desc_len, desc_path, desc_valid,
        output desc_ready
    );
endinterface

// File: rtl/drc_path_tracker.sv
// DMA read path tracker: binds pre-split PCIe reads to completion paths/tags and turns per-path
// completion beats into 4 KiB-safe AXI burst descriptors. Define DRC_CPL_TIMEOUT_EN for completion timeouts.
module drc_path_tracker #(
    parameter int         P_PATHS      = 4,
    parameter int         P_DW         = 4,
    parameter int         P_MAX_BURST  = 16,
    parameter logic [7:0] P_TAG_BASE   = 8'h10,
    parameter int         P_DESC_DEPTH = 16
`ifdef DRC_CPL_TIMEOUT_EN
    ,
    parameter int         P_TIMEOUT    = 4096
`endif
) (
    input  logic               i_clk,
    input  logic               i_rst,
    drc_path_tracker_if.slave  bus,
    output logic [P_PATHS-1:0] path_busy,
    output logic               err_stray,
    output logic               err_overrun,
`ifdef DRC_CPL_TIMEOUT_EN
    output logic               err_timeout,
`endif
    output logic               state_dbg
);
    localparam int PW = (P_PATHS > 1) ? $clog2(P_PATHS) : 1;
    localparam int AW = (P_DESC_DEPTH > 1) ? $clog2(P_DESC_DEPTH) : 1;
    localparam logic [AW:0] FIFO_FULL = (AW + 1)'(P_DESC_DEPTH);
    localparam logic [AW:0] FIFO_HALF = (AW + 1)'(P_DESC_DEPTH / 2);
    localparam logic [8:0]  MAX_BEATS = 9'(P_MAX_BURST);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;
    state_t state_q, state_d;

    logic [P_PATHS-1:0] busy_q;
    logic [12:0] remaining_q   [P_PATHS];
    logic [31:0] burst_start_q [P_PATHS];
    logic [31:0] cur_addr_q    [P_PATHS];
    logic [8:0]  beats_q       [P_PATHS];

    logic [31:0] dma_addr_q;
    logic [9:0]  dma_len_q;
    logic [7:0]  dma_tag_q;
    logic        err_stray_q, err_overrun_q;

    logic [31:0]   fifo_addr [P_DESC_DEPTH];
    logic [7:0]    fifo_len  [P_DESC_DEPTH];
    logic [PW-1:0] fifo_path [P_DESC_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic          free_found;
    logic [PW-1:0] free_idx;
    logic          accept;

    logic [7:0]    tag_off;
    logic          tag_in;
    logic [PW-1:0] hit_idx;
    logic          beat_hit, stray;
    logic [12:0]   beat_bytes, rem_next;
    logic [8:0]    beats_next;
    logic [31:0]   next_addr;
    logic          beat_overrun, beat_close, beat_done, beat_push;

    logic          push, pop, do_push;
    logic [31:0]   push_addr;
    logic [7:0]    push_len;
    logic [PW-1:0] push_path;

    // Lowest-index free path wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = P_PATHS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = PW'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && free_found && (count_q <= FIFO_HALF) && !i_rst) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.dma_read_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tag_off  = bus.cpl_tag - P_TAG_BASE;
    assign tag_in   = (tag_off < 8'(P_PATHS));
    assign hit_idx  = tag_off[PW-1:0];
    assign beat_hit = bus.cpl_valid && tag_in && busy_q[hit_idx];
    assign stray    = bus.cpl_valid && !beat_hit;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < P_DW; i++) begin
            if (bus.cpl_dwen[i]) beat_bytes = beat_bytes + 13'd4;
        end
    end

    // A burst closes on max length, short beat, landing on a 4 KiB boundary, or end of request.
    assign beat_overrun = beat_bytes > remaining_q[hit_idx];
    assign rem_next     = remaining_q[hit_idx] - beat_bytes;
    assign beats_next   = beats_q[hit_idx] + 9'd1;
    assign next_addr    = cur_addr_q[hit_idx] + 32'(beat_bytes);
    assign beat_done    = beat_overrun || (rem_next == 13'd0);
    assign beat_close   = beat_done || (beats_next == MAX_BEATS) ||
                          (bus.cpl_dwen != {P_DW{1'b1}}) || (next_addr[11:0] == 12'd0);
    assign beat_push    = beat_hit && beat_close;

`ifdef DRC_CPL_TIMEOUT_EN
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(P_TIMEOUT);

    logic [TW-1:0] to_cnt_q [P_PATHS];
    logic          to_found, to_fire, to_push, err_timeout_q;
    logic [PW-1:0] to_idx;

    always_comb begin
        to_found = 1'b0;
        to_idx   = '0;
        for (int i = P_PATHS - 1; i >= 0; i--) begin
            if (busy_q[i] && (to_cnt_q[i] == TO_LIMIT) && !(beat_hit && (hit_idx == PW'(i)))) begin
                to_found = 1'b1;
                to_idx   = PW'(i);
            end
        end
    end

    // A timeout waits a cycle if a completion push already owns the FIFO write port.
    assign to_fire = to_found && !beat_push;
    assign to_push = to_fire && (beats_q[to_idx] != 9'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < P_PATHS; i++) to_cnt_q[i] <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            for (int i = 0; i < P_PATHS; i++) begin
                if (!busy_q[i] || (accept && (free_idx == PW'(i))) || (beat_hit && (hit_idx == PW'(i))))
                    to_cnt_q[i] <= '0;
                else if (to_cnt_q[i] != TO_LIMIT)
                    to_cnt_q[i] <= to_cnt_q[i] + TW'(1);
            end
            if (to_fire) err_timeout_q <= 1'b1;
        end
    end

    assign err_timeout = err_timeout_q;
`endif

    always_comb begin
        push      = 1'b0;
        push_addr = '0;
        push_len  = '0;
        push_path = '0;
        if (beat_push) begin
            push      = 1'b1;
            push_addr = burst_start_q[hit_idx];
            push_len  = 8'(beats_next - 9'd1);
            push_path = hit_idx;
        end
`ifdef DRC_CPL_TIMEOUT_EN
        else if (to_push) begin
            push      = 1'b1;
            push_addr = burst_start_q[to_idx];
            push_len  = 8'(beats_q[to_idx] - 9'd1);
            push_path = to_idx;
        end
`endif
    end

    assign pop     = bus.desc_ready && (count_q != '0);
    assign do_push = push && ((count_q != FIFO_FULL) || pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
            for (int i = 0; i < P_PATHS; i++) begin
                remaining_q[i]   <= '0;
                burst_start_q[i] <= '0;
                cur_addr_q[i]    <= '0;
                beats_q[i]       <= '0;
            end
        end else begin
            if (accept) begin
                busy_q[free_idx]        <= 1'b1;
                remaining_q[free_idx]   <= bus.req_len;
                burst_start_q[free_idx] <= bus.req_dev_addr;
                cur_addr_q[free_idx]    <= bus.req_dev_addr;
                beats_q[free_idx]       <= '0;
            end
            if (beat_hit) begin
                remaining_q[hit_idx] <= beat_overrun ? 13'd0 : rem_next;
                beats_q[hit_idx]     <= beat_close ? 9'd0 : beats_next;
                cur_addr_q[hit_idx]  <= next_addr;
                if (beat_close) burst_start_q[hit_idx] <= next_addr;
                if (beat_done)  busy_q[hit_idx] <= 1'b0;
            end
`ifdef DRC_CPL_TIMEOUT_EN
            if (to_fire) begin
                busy_q[to_idx]        <= 1'b0;
                remaining_q[to_idx]   <= '0;
                beats_q[to_idx]       <= '0;
                burst_start_q[to_idx] <= cur_addr_q[to_idx];
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dma_addr_q    <= '0;
            dma_len_q     <= '0;
            dma_tag_q     <= '0;
            err_stray_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                dma_addr_q <= bus.req_host_addr;
                dma_len_q  <= bus.req_len[11:2];
                dma_tag_q  <= P_TAG_BASE + 8'(free_idx);
            end
            err_stray_q <= stray;
            if ((beat_hit && beat_overrun) || (push && !do_push)) err_overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                fifo_addr[wr_ptr_q] <= push_addr;
                fifo_len[wr_ptr_q]  <= push_len;
                fifo_path[wr_ptr_q] <= push_path;
                wr_ptr_q            <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(pop);
        end
    end

    assign bus.req_ready      = accept;
    assign bus.dma_read_valid = (state_q == S_ISSUE);
    assign bus.dma_read_addr  = dma_addr_q;
    assign bus.dma_read_len   = dma_len_q;
    assign bus.dma_read_tag   = dma_tag_q;
    // Head entry is masked while empty so stale RAM contents never reach the outputs.
    assign bus.desc_valid     = (count_q != '0);
    assign bus.desc_addr      = bus.desc_valid ? fifo_addr[rd_ptr_q] : 32'd0;
    assign bus.desc_len       = bus.desc_valid ? fifo_len[rd_ptr_q]  : 8'd0;
    assign bus.desc_path      = bus.desc_valid ? fifo_path[rd_ptr_q] : '0;
    assign path_busy          = busy_q;
    assign err_stray          = err_stray_q;
    assign err_overrun        = err_overrun_q;
    assign state_dbg          = state_q;
endmodule

// File: tb/tb_drc_path_tracker.sv
// Directed bench for drc_path_tracker: single request, 4 KiB split, short tail, concurrency,
// errors, FIFO back-pressure/overflow and reset mid-transfer.
module tb_drc_path_tracker;
    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    drc_path_tracker_if #(.P_PATHS(4), .P_DW(4)) bus ();

    logic [3:0] path_busy;
    logic       err_stray, err_overrun, state_dbg;
`ifdef DRC_CPL_TIMEOUT_EN
    logic       err_timeout;
`endif

    drc_path_tracker #(
        .P_PATHS(4), .P_DW(4), .P_MAX_BURST(16), .P_TAG_BASE(8'h10), .P_DESC_DEPTH(16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .bus         (bus.slave),
        .path_busy   (path_busy),
        .err_stray   (err_stray),
        .err_overrun (err_overrun),
`ifdef DRC_CPL_TIMEOUT_EN
        .err_timeout (err_timeout),
`endif
        .state_dbg   (state_dbg)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int stall_hits;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input string tag, input logic [31:0] host, input logic [31:0] dev,
                            input logic [12:0] len);
        logic got;
        bus.req_host_addr = host;
        bus.req_dev_addr  = dev;
        bus.req_len       = len;
        bus.req_valid     = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (bus.req_ready) got = 1'b1;
            else tick();
        end
        check({tag, "_ready"}, 32'(got), 32'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic issue_done();
        bus.dma_read_done = 1'b1;
        tick();
        bus.dma_read_done = 1'b0;
    endtask

    task automatic beat(input logic [7:0] tag, input logic [3:0] dwen);
        bus.cpl_tag   = tag;
        bus.cpl_dwen  = dwen;
        bus.cpl_valid = 1'b1;
        tick();
        bus.cpl_valid = 1'b0;
        bus.cpl_dwen  = 4'h0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] path);
        check({tag, "_valid"}, 32'(bus.desc_valid), 32'd1);
        check({tag, "_addr"},  bus.desc_addr, addr);
        check({tag, "_len"},   32'(bus.desc_len), 32'(len));
        check({tag, "_path"},  32'(bus.desc_path), 32'(path));
        bus.desc_ready = 1'b1;
        tick();
        bus.desc_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        bus.req_host_addr = '0; bus.req_dev_addr = '0; bus.req_len = '0; bus.req_valid = 1'b0;
        bus.dma_read_done = 1'b0;
        bus.cpl_tag = '0; bus.cpl_dwen = '0; bus.cpl_valid = 1'b0;
        bus.desc_ready = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        #1;
        check("rst_busy",  32'(path_busy), 32'd0);
        check("rst_desc",  32'(bus.desc_valid), 32'd0);
        check("rst_dma",   32'(bus.dma_read_valid), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_err",   32'({err_stray, err_overrun}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // Single 256-byte request: 16 full beats, one descriptor.
        send_req("t1", 32'h1000_0000, 32'h0000_0100, 13'd256);
        check("t1_dma_valid", 32'(bus.dma_read_valid), 32'd1);
        check("t1_dma_addr",  bus.dma_read_addr, 32'h1000_0000);
        check("t1_dma_len",   32'(bus.dma_read_len), 32'd64);
        check("t1_dma_tag",   32'(bus.dma_read_tag), 32'h10);
        check("t1_busy",      32'(path_busy), 32'b0001);
        issue_done();
        check("t1_dma_drop",  32'(bus.dma_read_valid), 32'd0);
        for (int i = 0; i < 15; i++) beat(8'h10, 4'hF);
        check("t1_no_desc_yet", 32'(bus.desc_valid), 32'd0);
        beat(8'h10, 4'hF);
        check("t1_freed", 32'(path_busy), 32'd0);
        pop_check("t1_desc", 32'h100, 8'd15, 2'd0);
        check("t1_empty", 32'(bus.desc_valid), 32'd0);

        // 4 KiB crossing splits into two bursts.
        send_req("t2", 32'h2000_0000, 32'h0000_0FC0, 13'd128);
        issue_done();
        for (int i = 0; i < 8; i++) beat(8'h10, 4'hF);
        check("t2_freed", 32'(path_busy), 32'd0);
        pop_check("t2_d0", 32'h0FC0, 8'd3, 2'd0);
        pop_check("t2_d1", 32'h1000, 8'd3, 2'd0);

        // Short tail beat closes the burst.
        send_req("t3", 32'h3000_0000, 32'h0000_2000, 13'd40);
        check("t3_dma_len", 32'(bus.dma_read_len), 32'd10);
        issue_done();
        beat(8'h10, 4'hF);
        beat(8'h10, 4'hF);
        beat(8'h10, 4'h3);
        check("t3_freed", 32'(path_busy), 32'd0);
        pop_check("t3_desc", 32'h2000, 8'd2, 2'd0);

        // Four concurrent paths, fifth request stalls until one frees.
        for (int i = 0; i < 4; i++) begin
            send_req("t4_req", 32'h4000_0000 + 32'(i * 256), 32'h3000 + 32'(i * 256), 13'd32);
            check("t4_tag", 32'(bus.dma_read_tag), 32'h10 + 32'(i));
            check("t4_busy", 32'(path_busy), (32'd1 << (i + 1)) - 32'd1);
            issue_done();
        end
        bus.req_host_addr = 32'h5000_0000;
        bus.req_dev_addr  = 32'h4000;
        bus.req_len       = 13'd16;
        bus.req_valid     = 1'b1;
        stall_hits = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.req_ready) stall_hits++;
            tick();
        end
        beat(8'h11, 4'hF); if (bus.req_ready) stall_hits++;
        beat(8'h13, 4'hF); if (bus.req_ready) stall_hits++;
        beat(8'h10, 4'hF); if (bus.req_ready) stall_hits++;
        beat(8'h12, 4'hF); if (bus.req_ready) stall_hits++;
        check("t4_stall", 32'(stall_hits), 32'd0);
        beat(8'h12, 4'hF);
        check("t4_busy_after_free", 32'(path_busy), 32'b1011);
        check("t4_fifth_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check("t4_fifth_tag", 32'(bus.dma_read_tag), 32'h12);
        check("t4_all_busy", 32'(path_busy), 32'b1111);
        issue_done();
        beat(8'h10, 4'hF);
        beat(8'h11, 4'hF);
        beat(8'h13, 4'hF);
        beat(8'h12, 4'hF);
        check("t4_all_free", 32'(path_busy), 32'd0);
        pop_check("t4_d0", 32'h3200, 8'd1, 2'd2);
        pop_check("t4_d1", 32'h3000, 8'd1, 2'd0);
        pop_check("t4_d2", 32'h3100, 8'd1, 2'd1);
        pop_check("t4_d3", 32'h3300, 8'd1, 2'd3);
        pop_check("t4_d4", 32'h4000, 8'd0, 2'd2);

        // Stray tag: one-cycle pulse, nothing else moves.
        beat(8'h20, 4'hF);
        check("t5_stray", 32'(err_stray), 32'd1);
        check("t5_stray_busy", 32'(path_busy), 32'd0);
        check("t5_stray_desc", 32'(bus.desc_valid), 32'd0);
        tick();
        check("t5_stray_pulse", 32'(err_stray), 32'd0);

        // Fill descriptor FIFO with one-dword beats: back-pressure past half, then overflow.
        send_req("t6", 32'h6000_0000, 32'h0000_8000, 13'd4096);
        check("t6_len4k", 32'(bus.dma_read_len), 32'd0);
        issue_done();
        for (int i = 0; i < 9; i++) beat(8'h10, 4'h1);
        bus.req_host_addr = 32'h7000_0000;
        bus.req_dev_addr  = 32'h9000;
        bus.req_len       = 13'd16;
        bus.req_valid     = 1'b1;
        stall_hits = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.req_ready) stall_hits++;
            tick();
        end
        bus.req_valid = 1'b0;
        check("t6_fifo_stall", 32'(stall_hits), 32'd0);
        for (int i = 0; i < 7; i++) beat(8'h10, 4'h1);
        check("t6_no_overrun", 32'(err_overrun), 32'd0);
        beat(8'h10, 4'h1);
        check("t6_overrun", 32'(err_overrun), 32'd1);
        check("t6_head_addr", bus.desc_addr, 32'h8000);
        bus.desc_ready = 1'b1;
        repeat (15) tick();
        bus.desc_ready = 1'b0;
        pop_check("t6_last", 32'h803C, 8'd0, 2'd0);
        check("t6_drained", 32'(bus.desc_valid), 32'd0);
        check("t6_path0_busy", 32'(path_busy), 32'b0001);

        // Reset while issuing with three busy paths and a queued descriptor.
        send_req("t7a", 32'h8000_0000, 32'h0000_A000, 13'd64);
        issue_done();
        send_req("t7b", 32'h9000_0000, 32'h0000_B000, 13'd64);
        beat(8'h10, 4'h1);
        check("t7_pre_busy",  32'(path_busy), 32'b0111);
        check("t7_pre_state", 32'(state_dbg), 32'd1);
        check("t7_pre_desc",  32'(bus.desc_valid), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("t7_busy",    32'(path_busy), 32'd0);
        check("t7_desc",    32'(bus.desc_valid), 32'd0);
        check("t7_dma",     32'(bus.dma_read_valid), 32'd0);
        check("t7_state",   32'(state_dbg), 32'd0);
        check("t7_overrun", 32'(err_overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
